dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory-side end of the CPU load/store (STW/LDW) interface.
//  - Accepts one request at a time from the CPU's load/store unit over a valid/ready handshake.
//  - Services the request with a programmable number of wait states.
//  - Returns read data, or a store acknowledge, over a valid/ready response channel.
//  - Sits between the CPU core and the word-addressed data RAM.
// PARAMETERS
//  DATA_W       16   data word width (CPU register width)
//  ADDR_W       16   word-address width from CPU
//  DEPTH        256  number of words implemented; addresses >= DEPTH are out of range
//  WAIT_CYCLES  1    wait states between accept and response (0..15 legal)
// PORTS
//  CLK          in   1       clock, rising edge
//  reset_n      in   1       reset, asynchronous, active-low
//  req_valid    in   1       CPU presents a request
//  req_ready    out  1       responder can accept a request
//  req_we       in   1       1 = store (STW), 0 = load (LDW)
//  req_addr     in   ADDR_W  word address
//  req_wdata    in   DATA_W  store data
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       CPU takes the response
//  rsp_rdata    out  DATA_W  load data; 0 for stores and errors
//  rsp_err      out  1       request address was out of range
// BEHAVIOUR
//  Reset and clock: one clock; reset is asynchronous and active-low.
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0.
//  RAM contents are not reset.
//  FSM states:
//   IDLE    req_ready=1; on req_valid: latch we/addr/wdata.
//           Go to ACCESS if WAIT_CYCLES>0, else RESP.
//   ACCESS  req_ready=0; count down WAIT_CYCLES-1..0; at 0 go to RESP.
//   RESP    rsp_valid=1; hold rsp_rdata and rsp_err stable.
//           On rsp_ready, go to IDLE.
//  Commit edge: the edge entering RESP.
//   - Store writes the RAM.
//   - Load samples the RAM into rsp_rdata.
//   - rsp_err is computed here (addr >= DEPTH).
//  Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
//  One outstanding request at most:
//   - req_ready=0 from the accept edge until the cycle after the response handshake.
//   - There is no same-cycle accept while rsp_valid=1.
//  Out of range: store suppressed, rsp_rdata=0, rsp_err=1.
//   Address is compared at full ADDR_W width; no wrap-around aliasing.
//  Read-after-write: a load following a store to the same address returns the new data.
//  Backpressure: rsp_valid holds and outputs stay stable indefinitely while rsp_ready=0.
//  Reset mid-operation:
//   - Returns to IDLE with the reset values above.
//   - A store that has not reached its commit edge is discarded.
//  Request fields are sampled only at the accept edge; later changes are ignored.
//  Arithmetic: all indexing is unsigned.
// CONFIGURATION
//  DMEM_BYTE_EN_EN defined:
//   - Adds input req_be[1:0].
//   - A store writes byte lane i only when req_be[i]=1; req_be=2'b00 is a legal no-op store,
//     still acknowledged.
//   - Loads ignore req_be and always return the full word.
//  DMEM_BYTE_EN_EN undefined: there is no req_be port, and every store writes the full word.
// STRUCTURE
//  Shared package cpu_pkg:
//   - DATA_W and ADDR_W defaults
//   - OP_STW/OP_LDW opcode constants
//   - dmem FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
//  Sub-module dmem_array: single-port synchronous RAM.
//   - Inputs: CLK, we, addr, wdata, optional be.
//   - Output: registered rdata.
//   - No reset on storage.
//  dmem_responder contains the FSM, wait counter, range check and response registers only.
// TESTING
//  1 Reset: hold reset_n=0 -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0;
//    release, idle 5 cycles -> outputs unchanged.
//  2 Store/load, WAIT_CYCLES=1:
//    STW addr=0x0010 data=0xBEEF -> rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0;
//    then LDW 0x0010 -> rsp_rdata=0xBEEF.
//  3 Backpressure: LDW with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable,
//    req_ready=0; second req_valid not accepted until the cycle after rsp_ready=1.
//  4 Out of range, DEPTH=256: STW addr=0x0100 data=0x1234 -> rsp_err=1; LDW 0x0100 -> rsp_err=1,
//    rsp_rdata=0; LDW 0x0000 unchanged, i.e. no alias.
//  5 Reset mid-store: accept STW 0x0005 data=0xAAAA with WAIT_CYCLES=3, assert reset_n=0 after
//    1 cycle -> LDW 0x0005 returns its prior value.
//  6 DMEM_BYTE_EN_EN: word 0x1122 at 0x0003, STW 0x0003 data=0xFFFF req_be=2'b01 ->
//    LDW returns 0x11FF; WAIT_CYCLES=0 -> latency 1 cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions used by the data-memory responder.
//                Holds the default data/address widths, the load/store
//                opcode values carried on req_we and the responder FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default CPU register width and word-address width
    localparam int unsigned c_DATA_W = 16;
    localparam int unsigned c_ADDR_W = 16;

    // Opcode values as carried on the req_we line
    localparam logic c_OP_STW = 1'b1;
    localparam logic c_OP_LDW = 1'b0;

    // Data-memory responder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port synchronous word RAM with byte-lane write
//                enables. A write updates only the lanes whose be_i bit is
//                set; a read (re_i without we_i) loads the registered read
//                data, which otherwise holds its last value. Storage has no
//                reset.
//  Ports       : CLK      in  clock, rising edge
//                we_i     in  write enable
//                re_i     in  read enable (load rdata_o register)
//                addr_i   in  word index
//                wdata_i  in  write data
//                be_i     in  byte-lane write enables
//                rdata_o  out registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                  CLK,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned c_BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side end of the CPU load/store interface. Accepts
//                one request at a time, waits WAIT_CYCLES cycles, then
//                commits the access (store writes RAM / load reads RAM) on
//                the edge that enters RESP and holds the response until the
//                CPU takes it.
//                Optional feature macro: DMEM_BYTE_EN_EN adds req_be for
//                byte-lane stores; without it every store writes the full
//                word.
//  Ports       : CLK        in  clock, rising edge
//                reset_n    in  asynchronous active-low reset
//                req_valid  in  request present
//                req_ready  out request can be accepted
//                req_we     in  1 = store, 0 = load
//                req_addr   in  word address
//                req_wdata  in  store data
//                req_be     in  byte enables (DMEM_BYTE_EN_EN only)
//                rsp_valid  out response present
//                rsp_ready  in  response taken
//                rsp_rdata  out load data, 0 for stores and errors
//                rsp_err    out address out of range
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = c_DATA_W,
    parameter int unsigned ADDR_W      = c_ADDR_W,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned     c_BE_W       = DATA_W / 8;
    localparam int unsigned     c_IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     c_CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]      c_CNT_INIT   = 4'(c_CNT_INIT_I);
    localparam logic [ADDR_W:0] c_DEPTH_EXT  = (ADDR_W+1)'(DEPTH);

    dmem_state_e         state_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic                load_q;      // response carries RAM read data
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [c_BE_W-1:0]   be_q;

    logic [c_BE_W-1:0]   w_be_in;
    logic                w_accept;
    logic                w_commit;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [c_BE_W-1:0]   w_be;
    logic                w_oor;
    logic                w_is_store;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [DATA_W-1:0]   w_ram_rdata;

`ifdef DMEM_BYTE_EN_EN
    assign w_be_in = req_be;
`else
    assign w_be_in = '1;
`endif

    assign w_accept = (state_q == ST_IDLE) && req_valid;

    // With zero wait states the commit edge is the accept edge itself, so the
    // RAM must see the live request fields rather than the latched copies.
    assign w_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign w_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign w_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign w_be    = (state_q == ST_IDLE) ? w_be_in   : be_q;

    assign w_commit = (w_accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_ACCESS) && (cnt_q == 4'd0));

    // Full-width compare: high address bits never alias into the array
    assign w_oor      = ({1'b0, w_addr} >= c_DEPTH_EXT);
    assign w_is_store = (w_we == c_OP_STW);
    assign w_ram_we   = w_commit && w_is_store && !w_oor;
    assign w_ram_re   = w_commit && !w_is_store && !w_oor;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_array (
        .CLK     (CLK),
        .we_i    (w_ram_we),
        .re_i    (w_ram_re),
        .addr_i  (w_addr[c_IDX_W-1:0]),
        .wdata_i (w_wdata),
        .be_i    (w_be),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= w_be_in;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ACCESS;
                        cnt_q       <= c_CNT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        load_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Entering RESP overrides the IDLE/ACCESS updates above
            if (w_commit) begin
                state_q     <= ST_RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= w_oor;
                load_q      <= !w_is_store && !w_oor;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // RAM read register only reloads on a load commit, so this is stable in RESP
    assign rsp_rdata = (state_q == ST_RESP && load_q) ? w_ram_rdata : '0;

endmodule : dmem_responder
`default_nettype wire
